// File: rtl/systolic_pkg.sv
// Shared types and timing helpers for the systolic array scheduler and its operand buffers.
package systolic_pkg;

    localparam int DEFAULT_BIT_WIDTH = 8;

    typedef logic [DEFAULT_BIT_WIDTH-1:0] operand_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } sched_state_t;

    function automatic int feedLen(input int dim);
        return 2 * dim - 1;
    endfunction

    // Covers the DIM-1 hops to the far corner, the cell commit latency and the
    // extra cycle of the feeder's own output register in front of the mesh edge.
    function automatic int drainLen(input int dim, input int cellLat);
        return dim + cellLat;
    endfunction

endpackage

// File: rtl/systolic_skew_buf.sv
// DIM x DIM operand buffer with a write port and a diagonally skewed read port.
module systolic_skew_buf #(
    parameter int BIT_WIDTH = 8,
    parameter int DIM       = 4,
    parameter int IDX_W     = 2,
    parameter int T_W       = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     wrEn_i,
    input  logic [IDX_W-1:0]         wrRow_i,
    input  logic [IDX_W-1:0]         wrCol_i,
    input  logic [BIT_WIDTH-1:0]     wrData_i,
    input  logic [T_W-1:0]           rdT_i,
    input  logic                     colMajor_i,
    output logic [DIM-1:0]           rdEn_o,
    output logic [DIM*BIT_WIDTH-1:0] rdData_o
);

    logic [BIT_WIDTH-1:0] mem_q [DIM][DIM];

    // Indices beyond DIM-1 are only reachable when DIM is not a power of two; they are dropped.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (wrEn_i && (int'(wrRow_i) < DIM) && (int'(wrCol_i) < DIM)) begin
            mem_q[wrRow_i][wrCol_i] <= wrData_i;
        end
    end

    // Lane i carries element k = t - i of its row (A) or column (B) while 0 <= k < DIM.
    always_comb begin
        rdEn_o   = '0;
        rdData_o = '0;
        for (int i = 0; i < DIM; i++) begin
            int k;
            k = int'(rdT_i) - i;
            if ((k >= 0) && (k < DIM)) begin
                rdEn_o[i] = 1'b1;
                if (colMajor_i) begin
                    rdData_o[i*BIT_WIDTH +: BIT_WIDTH] = mem_q[IDX_W'(k)][IDX_W'(i)];
                end else begin
                    rdData_o[i*BIT_WIDTH +: BIT_WIDTH] = mem_q[IDX_W'(i)][IDX_W'(k)];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_array_sched.sv
// Scheduler/feeder for a DIM x DIM systolic mesh: clears the accumulators, streams skewed A/B edges, pulses done.
module systolic_array_sched
    import systolic_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int DIM       = 4,
    parameter int CELL_LAT  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     ld_en,
    input  logic                     ld_sel,
    input  logic [$clog2(DIM)-1:0]   ld_row,
    input  logic [$clog2(DIM)-1:0]   ld_col,
    input  logic [BIT_WIDTH-1:0]     ld_data,
    output logic                     arr_clr,
    output logic [DIM-1:0]           en_in_a,
    output logic [DIM*BIT_WIDTH-1:0] in_a,
    output logic [DIM-1:0]           en_in_b,
    output logic [DIM*BIT_WIDTH-1:0] in_b
);

    localparam int IDX_W     = $clog2(DIM);
    localparam int CNT_W     = $clog2(2 * DIM);
    localparam int FEED_LEN  = feedLen(DIM);
    localparam int DRAIN_LEN = drainLen(DIM, CELL_LAT);

    sched_state_t           state_q;
    logic [CNT_W-1:0]       feedT_q;
    logic [CNT_W-1:0]       feedT_d;
    logic [CNT_W-1:0]       drainCnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   arrClr_q;
    logic [DIM-1:0]         enA_q;
    logic [DIM-1:0]         enB_q;
    logic [DIM*BIT_WIDTH-1:0] inA_q;
    logic [DIM*BIT_WIDTH-1:0] inB_q;

    logic                   wrEn;
    logic [DIM-1:0]         skewEnA;
    logic [DIM-1:0]         skewEnB;
    logic [DIM*BIT_WIDTH-1:0] skewDataA;
    logic [DIM*BIT_WIDTH-1:0] skewDataB;

    assign wrEn    = ld_en && ((state_q == IDLE) || (state_q == DONE));
    // The skew ports look up the step about to be registered, so the edges change with the counter.
    assign feedT_d = (state_q == FEED) ? feedT_q + CNT_W'(1) : '0;

    systolic_skew_buf #(
        .BIT_WIDTH (BIT_WIDTH),
        .DIM       (DIM),
        .IDX_W     (IDX_W),
        .T_W       (CNT_W)
    ) bufA (
        .clk_i      (clk),
        .reset_i    (reset),
        .wrEn_i     (wrEn && !ld_sel),
        .wrRow_i    (ld_row),
        .wrCol_i    (ld_col),
        .wrData_i   (ld_data),
        .rdT_i      (feedT_d),
        .colMajor_i (1'b0),
        .rdEn_o     (skewEnA),
        .rdData_o   (skewDataA)
    );

    systolic_skew_buf #(
        .BIT_WIDTH (BIT_WIDTH),
        .DIM       (DIM),
        .IDX_W     (IDX_W),
        .T_W       (CNT_W)
    ) bufB (
        .clk_i      (clk),
        .reset_i    (reset),
        .wrEn_i     (wrEn && ld_sel),
        .wrRow_i    (ld_row),
        .wrCol_i    (ld_col),
        .wrData_i   (ld_data),
        .rdT_i      (feedT_d),
        .colMajor_i (1'b1),
        .rdEn_o     (skewEnB),
        .rdData_o   (skewDataB)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            feedT_q    <= '0;
            drainCnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            arrClr_q   <= 1'b0;
            enA_q      <= '0;
            enB_q      <= '0;
            inA_q      <= '0;
            inB_q      <= '0;
        end else begin
            arrClr_q <= 1'b0;
            done_q   <= 1'b0;
            enA_q    <= '0;
            enB_q    <= '0;
            inA_q    <= '0;
            inB_q    <= '0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= CLEAR;
                        arrClr_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q <= FEED;
                    feedT_q <= feedT_d;
                    enA_q   <= skewEnA;
                    enB_q   <= skewEnB;
                    inA_q   <= skewDataA;
                    inB_q   <= skewDataB;
                end
                FEED: begin
                    if (feedT_q == CNT_W'(FEED_LEN - 1)) begin
                        state_q    <= DRAIN;
                        drainCnt_q <= '0;
                    end else begin
                        feedT_q <= feedT_d;
                        enA_q   <= skewEnA;
                        enB_q   <= skewEnB;
                        inA_q   <= skewDataA;
                        inB_q   <= skewDataB;
                    end
                end
                DRAIN: begin
                    if (drainCnt_q == CNT_W'(DRAIN_LEN - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drainCnt_q <= drainCnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign arr_clr = arrClr_q;
    assign en_in_a = enA_q;
    assign en_in_b = enB_q;
    assign in_a    = inA_q;
    assign in_b    = inB_q;

endmodule

// File: tb/tb_systolic_array_sched.sv
// Randomized self-checking bench for systolic_array_sched against a wavefront reference model.
module tb_systolic_array_sched;

    localparam int BW         = 8;
    localparam int DIM        = 4;
    localparam int CL         = 1;
    localparam int IW         = $clog2(DIM);
    localparam int FEED_STEPS = 2 * DIM - 1;
    localparam int RUN_LEN    = 3 * DIM + CL + 1;

    logic                clk;
    logic                reset;
    logic                start;
    logic                busy;
    logic                done;
    logic                ld_en;
    logic                ld_sel;
    logic [IW-1:0]       ld_row;
    logic [IW-1:0]       ld_col;
    logic [BW-1:0]       ld_data;
    logic                arr_clr;
    logic [DIM-1:0]      en_in_a;
    logic [DIM*BW-1:0]   in_a;
    logic [DIM-1:0]      en_in_b;
    logic [DIM*BW-1:0]   in_b;

    int numChecks;
    int numErrors;

    logic [BW-1:0]     refA [DIM][DIM];
    logic [BW-1:0]     refB [DIM][DIM];
    logic [DIM-1:0]    expEnA [FEED_STEPS];
    logic [DIM-1:0]    expEnB [FEED_STEPS];
    logic [DIM*BW-1:0] expInA [FEED_STEPS];
    logic [DIM*BW-1:0] expInB [FEED_STEPS];
    logic [DIM-1:0]    capEnA [RUN_LEN+2];
    logic [DIM*BW-1:0] capInA [RUN_LEN+2];
    logic [DIM*BW-1:0] capInB [RUN_LEN+2];

    systolic_array_sched #(
        .BIT_WIDTH (BW),
        .DIM       (DIM),
        .CELL_LAT  (CL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .ld_en   (ld_en),
        .ld_sel  (ld_sel),
        .ld_row  (ld_row),
        .ld_col  (ld_col),
        .ld_data (ld_data),
        .arr_clr (arr_clr),
        .en_in_a (en_in_a),
        .in_a    (in_a),
        .en_in_b (en_in_b),
        .in_b    (in_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numErrors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scatter each matrix element to the feed step at which it enters the mesh edge.
    task automatic buildExpected();
        for (int s = 0; s < FEED_STEPS; s++) begin
            expEnA[s] = '0;
            expEnB[s] = '0;
            expInA[s] = '0;
            expInB[s] = '0;
        end
        for (int i = 0; i < DIM; i++) begin
            for (int k = 0; k < DIM; k++) begin
                expEnA[i+k][i]          = 1'b1;
                expInA[i+k][i*BW +: BW] = refA[i][k];
                expEnB[k+i][i]          = 1'b1;
                expInB[k+i][i*BW +: BW] = refB[k][i];
            end
        end
    endtask

    task automatic loadElem(input bit sel, input int r, input int c, input logic [BW-1:0] d);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_row  = IW'(r);
        ld_col  = IW'(c);
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        if (sel) refB[r][c] = d;
        else     refA[r][c] = d;
    endtask

    // mode 0 loads the directed pattern, any other mode loads random operands.
    task automatic applyStimulus(input int mode);
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                if (mode == 0) begin
                    loadElem(1'b0, r, c, BW'(10 * r + c));
                    loadElem(1'b1, r, c, BW'(r + c));
                end else begin
                    loadElem(1'b0, r, c, BW'($urandom_range(0, 255)));
                    loadElem(1'b1, r, c, BW'($urandom_range(0, 255)));
                end
            end
        end
    endtask

    task automatic checkCycle(input string lbl, input int c);
        int t;
        logic [DIM-1:0]    eA;
        logic [DIM-1:0]    eB;
        logic [DIM*BW-1:0] dA;
        logic [DIM*BW-1:0] dB;
        t  = c - 2;
        eA = '0;
        eB = '0;
        dA = '0;
        dB = '0;
        if ((t >= 0) && (t < FEED_STEPS)) begin
            eA = expEnA[t];
            eB = expEnB[t];
            dA = expInA[t];
            dB = expInB[t];
        end
        checkOutput($sformatf("%s c%0d busy", lbl, c), 64'(busy), 64'((c >= 1) && (c <= RUN_LEN - 1)));
        checkOutput($sformatf("%s c%0d done", lbl, c), 64'(done), 64'(c == RUN_LEN));
        checkOutput($sformatf("%s c%0d arr_clr", lbl, c), 64'(arr_clr), 64'(c == 1));
        checkOutput($sformatf("%s c%0d en_in_a", lbl, c), 64'(en_in_a), 64'(eA));
        checkOutput($sformatf("%s c%0d in_a", lbl, c), 64'(in_a), 64'(dA));
        checkOutput($sformatf("%s c%0d en_in_b", lbl, c), 64'(en_in_b), 64'(eB));
        checkOutput($sformatf("%s c%0d in_b", lbl, c), 64'(in_b), 64'(dB));
        capEnA[c] = en_in_a;
        capInA[c] = in_a;
        capInB[c] = in_b;
    endtask

    // Checks every cycle of nRuns runs plus the idle cycle after each; hold keeps start high throughout.
    task automatic runTrace(input string lbl, input int nRuns, input bit hold, input bit poke);
        buildExpected();
        start = 1'b1;
        for (int r = 0; r < nRuns; r++) begin
            for (int c = 1; c <= RUN_LEN + 1; c++) begin
                @(posedge clk);
                #1;
                if (!hold) start = 1'b0;
                ld_en = 1'b0;
                checkCycle(lbl, c);
                if (poke && (c == 3)) begin
                    ld_en   = 1'b1;
                    ld_sel  = 1'b0;
                    ld_row  = '0;
                    ld_col  = '0;
                    ld_data = 8'd99;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic checkAllIdle(input string lbl);
        checkOutput({lbl, " busy"}, 64'(busy), 64'd0);
        checkOutput({lbl, " done"}, 64'(done), 64'd0);
        checkOutput({lbl, " arr_clr"}, 64'(arr_clr), 64'd0);
        checkOutput({lbl, " en_in_a"}, 64'(en_in_a), 64'd0);
        checkOutput({lbl, " in_a"}, 64'(in_a), 64'd0);
        checkOutput({lbl, " en_in_b"}, 64'(en_in_b), 64'd0);
        checkOutput({lbl, " in_b"}, 64'(in_b), 64'd0);
    endtask

    task automatic abortRun();
        buildExpected();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("abort t2 en_in_a", 64'(en_in_a), 64'(expEnA[2]));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkAllIdle("abort after reset");
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("abort quiet n%0d done", n), 64'(done), 64'd0);
            checkOutput($sformatf("abort quiet n%0d busy", n), 64'(busy), 64'd0);
        end
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                refA[r][c] = '0;
                refB[r][c] = '0;
            end
        end
    endtask

    initial begin
        numChecks = 0;
        numErrors = 0;
        reset     = 1'b1;
        start     = 1'b0;
        ld_en     = 1'b0;
        ld_sel    = 1'b0;
        ld_row    = '0;
        ld_col    = '0;
        ld_data   = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                refA[r][c] = '0;
                refB[r][c] = '0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checkAllIdle("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed pattern run with a write attempted while busy");
        applyStimulus(0);
        runTrace("dir", 1, 1'b0, 1'b1);
        checkOutput("dir t0 en_in_a", 64'(capEnA[2]), 64'h1);
        checkOutput("dir t3 in_a", 64'(capInA[5]), 64'h1e150c03);
        checkOutput("dir t3 en_in_a", 64'(capEnA[5]), 64'hf);
        checkOutput("dir t6 in_a", 64'(capInA[8]), 64'h21000000);
        checkOutput("dir t6 in_b", 64'(capInB[8]), 64'h06000000);

        runTrace("rerun", 1, 1'b0, 1'b0);
        checkOutput("rerun t0 in_a", 64'(capInA[2]), 64'h0);

        $display("[TB] reset during feed");
        abortRun();
        runTrace("zeroed", 1, 1'b0, 1'b0);

        $display("[TB] random operand runs");
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1);
            ld_en   = 1'b1;
            ld_sel  = n[0];
            ld_row  = IW'(DIM - 1);
            ld_col  = IW'($urandom_range(0, DIM - 1));
            ld_data = BW'($urandom_range(0, 255));
            if (ld_sel) refB[DIM-1][ld_col] = ld_data;
            else        refA[DIM-1][ld_col] = ld_data;
            runTrace($sformatf("rnd%0d", n), 1, 1'b0, 1'b0);
        end

        $display("[TB] start held high across back-to-back runs");
        runTrace("hold", 2, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
